dram_responder: RTL
===================

// Module: dram_responder
// PURPOSE
//  Memory-side responder of the CVP14 Addr/RD/WR/DataIn/DataOut bus: accepts read and write
//  strobes from the processor, services them from an internal word array, returns read data
//  after a fixed programmable latency. Synthesizable replacement for the behavioural DRAM used
//  in the CVP14 bench. Single clock domain, sits directly on the processor bus pins.
// PARAMETERS
//  AW       16   address width (word addressed)
//  DW       16   data width
//  DEPTH    4096 words implemented; Addr >= DEPTH aliases via Addr % DEPTH (low log2 bits)
//  RD_LAT   2    cycles from RD accept to Valid (legal 1..7)
//  INIT_HEX ""   simulation-only $readmemh image; empty -> array contents undefined (X)
// PORTS
//  Clk1     in  1   clock, all state on rising edge
//  Reset_l  in  1   asynchronous, active-low reset
//  Addr     in  AW  word address from CVP14, sampled on accept
//  RD       in  1   read strobe, one cycle per request
//  WR       in  1   write strobe, one cycle per request
//  DataIn   in  DW  write data from CVP14 (its DataOut), sampled with WR
//  DataOut  out DW  read data to CVP14 (its DataIn), held until next read completes
//  Valid    out 1   one-cycle pulse: DataOut carries new read data this cycle
//  Busy     out 1   read in flight; new strobes not accepted
//  Err      out 1   sticky: strobe dropped or RD&WR together; cleared only by reset
// BEHAVIOUR
//  Reset (Reset_l=0, async): state IDLE, DataOut=0, Valid=0, Busy=0, Err=0, counter=0;
//   array contents NOT cleared. Reset mid-read aborts it: no Valid pulse afterwards.
//  FSM states: IDLE, RWAIT, RDONE.
//   IDLE : WR=1,RD=0 -> mem[Addr]<=DataIn at that edge, stay IDLE (write latency 1, no ack).
//          RD=1,WR=0 -> latch Addr, cnt<=RD_LAT-1, Busy=1; RD_LAT==1 -> RDONE else RWAIT.
//          RD=1,WR=1 -> write performed, read dropped, Err<=1.
//   RWAIT: cnt decrements each cycle; cnt==1 -> RDONE. Any RD/WR here is dropped, Err<=1.
//   RDONE: DataOut<=mem[latched addr], Valid=1 for exactly this cycle, Busy=0 -> IDLE.
//          Strobes in RDONE are dropped (Err<=1); back-to-back reads need one idle cycle.
//  Latency: RD sampled at edge N -> Valid high in cycle N+RD_LAT, DataOut stable from then.
//  Read data is array value at RDONE edge; a write to same address before that cannot occur
//   (writes are dropped while Busy), so no bypass path needed.
//  DataOut holds last read value indefinitely; writes never change DataOut.
//  Address wrap: Addr=DEPTH+k accesses word k, no Err.
//  X on RD/WR treated as 0 in synthesis; bench must drive known values.
// STRUCTURE
//  Package cvp14_bus_pkg: AW/DW defaults, FSM state enum (IDLE/RWAIT/RDONE), RD_LAT bounds.
//  Sub-module dram_array: DEPTH x DW, one sync write port, one registered read port,
//   optional INIT_HEX load; responder holds FSM, latency counter, Err, DataOut register.
// TESTING
//  1. Reset_l=0 then 1, no strobes -> DataOut=0000, Valid=0, Busy=0, Err=0.
//  2. WR Addr=0010 DataIn=BEEF; next cycle RD Addr=0010 (RD_LAT=2) -> Valid 2 cycles after
//     RD edge, DataOut=BEEF, Busy high exactly 2 cycles, Err=0.
//  3. RD 0010 then RD 0011 one cycle later -> second dropped, Err=1, only one Valid, BEEF.
//  4. RD and WR same cycle Addr=0020 DataIn=1234 -> Err=1, no Valid; later RD 0020 -> 1234.
//  5. WR Addr=1005 (DEPTH=4096) DataIn=CAFE; RD Addr=0005 -> DataOut=CAFE, Err stays 0.
//  6. RD 0010 then Reset_l pulse low during RWAIT -> Valid never pulses, all outputs 0,
//     subsequent RD 0010 returns BEEF (array survives reset); repeat with RD_LAT=1 and 7.

Source files
------------

// File: rtl/cvp14_bus_pkg.sv
// Shared definitions for the CVP14 memory bus: default widths, responder FSM
// states and the legal read-latency range.
package cvp14_bus_pkg;

  localparam int AW_DEF     = 16;
  localparam int DW_DEF     = 16;
  localparam int DEPTH_DEF  = 4096;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;
  // Wide enough to hold RD_LAT_MAX-1.
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RWAIT = 2'd1,
    RDONE = 2'd2
  } state_t;

endpackage

// File: rtl/dram_array.sv
// Word storage for the responder: one synchronous write port and one
// registered read port. Contents are never reset.
module dram_array
  import cvp14_bus_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port: data lands in the array at the strobe edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered, captured one edge before the responder publishes it.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder for the CVP14 bus. Writes complete at the strobe edge;
// reads return on DataOut with a one-cycle Valid pulse RD_LAT edges after the
// strobe. Strobes arriving while a read is in flight are dropped and flagged
// on the sticky Err output.
module dram_responder
  import cvp14_bus_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = 2
) (
  input  logic          Clk1,
  input  logic          Reset_l,
  input  logic [AW-1:0] Addr,
  input  logic          RD,
  input  logic          WR,
  input  logic [DW-1:0] DataIn,
  output logic [DW-1:0] DataOut,
  output logic          Valid,
  output logic          Busy,
  output logic          Err
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LAT - 1);

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IW-1:0]   addr_q;
  logic [IW-1:0]   raddr;
  logic [DW-1:0]   rdata;
  logic            we, re, accept, err_set, valid_nxt;
  logic            unused_addr_hi;

  // Addresses at or above DEPTH alias onto the low index bits.
  assign unused_addr_hi = ^Addr[AW-1:IW];

  // With RD_LAT==1 the array read issues on the accept edge itself, before
  // addr_q holds the address, so take it straight from the bus in IDLE.
  assign raddr = (state == IDLE) ? Addr[IW-1:0] : addr_q;
  assign Busy  = (state != IDLE);

  // Next-state, strobe acceptance and error detection.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we        = 1'b0;
    re        = 1'b0;
    accept    = 1'b0;
    err_set   = 1'b0;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        we = WR;
        if (RD && WR) begin
          err_set = 1'b1;
        end else if (RD) begin
          accept  = 1'b1;
          cnt_nxt = LAT_M1;
          if (RD_LAT == 1) begin
            state_nxt = RDONE;
            re        = 1'b1;
          end else begin
            state_nxt = RWAIT;
          end
        end
      end
      RWAIT: begin
        err_set = RD | WR;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = RDONE;
          re        = 1'b1;
        end
      end
      RDONE: begin
        err_set   = RD | WR;
        valid_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, latched read address, sticky error and the output register.
  always_ff @(posedge Clk1 or negedge Reset_l) begin
    if (!Reset_l) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      Err     <= 1'b0;
      Valid   <= 1'b0;
      DataOut <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      Err   <= Err | err_set;
      Valid <= valid_nxt;
      if (accept)    addr_q  <= Addr[IW-1:0];
      if (valid_nxt) DataOut <= rdata;
    end
  end

  dram_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (Clk1),
    .we    (we),
    .waddr (Addr[IW-1:0]),
    .wdata (DataIn),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule
